axis_burst_tx: RTL and testbench
================================

AXIS_BURST_TX -- requirements
Module: axis_burst_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the stream data width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the buffer depth in words; a power of two.
REQ-003 Parameter ADDR_WIDTH, default 4, SHALL equal log2(DEPTH).
REQ-004 Parameter LEN_WIDTH, default 12, SHALL set the packet length field width.
REQ-005 Port m01_axis_aclk, input, 1 bit: the single clock. All logic SHALL be on its rising edge.
REQ-006 Port m01_axis_aresetn, input, 1 bit: reset. Reset SHALL be synchronous and active-low.
REQ-007 Port wr_en, input, 1 bit: pushes wr_data into the buffer.
REQ-008 Port wr_data, input, DATA_WIDTH bits: the word to buffer.
REQ-009 Port wr_full, output, 1 bit: the buffer holds DEPTH words.
REQ-010 Port pkt_len, input, LEN_WIDTH bits: the number of beats per packet.
REQ-011 Port m01_axis_tready, input, 1 bit: downstream ready.
REQ-012 Port m01_axis_tdata, output, DATA_WIDTH bits: stream data.
REQ-013 Port m01_axis_tstrb, output, DATA_WIDTH/8 bits: byte strobes.
REQ-014 Port m01_axis_tvalid, output, 1 bit: stream valid.
REQ-015 Port m01_axis_tlast, output, 1 bit: final beat of a packet.
REQ-016 Port fifo_count, output, ADDR_WIDTH+1 bits: the buffered word count.
REQ-017 Port pkt_done, output, 1 bit: a one-cycle pulse after each tlast handshake.

Function
REQ-018 A write SHALL be accepted when wr_en=1 and wr_full=0; a write while full SHALL be dropped, even if a pop occurs in the same cycle.
REQ-019 A handshake SHALL occur when tvalid=1 and tready=1; each handshake pops exactly one word, in FIFO order.
REQ-020 m01_axis_tvalid SHALL equal (fifo_count != 0), driven from registered state; a write into an empty buffer SHALL raise tvalid on the next cycle.
REQ-021 m01_axis_tdata SHALL be the head word and SHALL remain stable while tvalid=1 and tready=0.
REQ-022 m01_axis_tstrb SHALL be all ones when tvalid=1, else zero.
REQ-023 A simultaneous accepted write and handshake SHALL leave fifo_count unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 The FSM SHALL have two states: IDLE (no packet open) and ACTIVE (packet open).
REQ-026 In IDLE, the first handshake SHALL latch len_q = max(pkt_len, 1) and clear beat_cnt.
- If len_q = 1, the FSM SHALL remain in IDLE.
- Otherwise, beat_cnt SHALL become 1 and the FSM SHALL go to ACTIVE.
REQ-027 In ACTIVE, each handshake SHALL increment beat_cnt; the handshake where beat_cnt = len_q-1 SHALL return the FSM to IDLE.
REQ-028 m01_axis_tlast SHALL equal tvalid AND the following term:
- in IDLE: max(pkt_len, 1) = 1;
- in ACTIVE: beat_cnt = len_q-1.
REQ-029 A pkt_len change while ACTIVE SHALL have no effect until the next packet.
REQ-030 The buffer running empty mid-packet SHALL drop tvalid and hold the FSM state and beat_cnt; the packet SHALL resume on the next word.
REQ-031 pkt_done SHALL pulse high for exactly one cycle, in the cycle after a tlast handshake.
REQ-032 fifo_count SHALL saturate at DEPTH; wr_full SHALL equal (fifo_count = DEPTH).

Reset
REQ-033 While m01_axis_aresetn=0 at a clock edge, the block SHALL clear pointers, fifo_count, beat_cnt, len_q and pkt_done, and SHALL enter IDLE.
REQ-034 During reset, tvalid, tlast, tstrb and wr_full SHALL be 0; tdata is don't-care.
REQ-035 A reset mid-packet SHALL discard all buffered words and the open packet.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE=0, ACTIVE=1) and the DATA_WIDTH/DEPTH defaults.
REQ-037 The buffer SHALL be a sub-module sync_fifo (single clock, with count output); the packetizer FSM SHALL remain in axis_burst_tx.

Verification
REQ-038 The bench SHALL cover these scenarios:
- Basic packet: pkt_len=3; write 0x55, 0x22, 0x24; tready=1 → three beats in order, tlast on 0x24 only, pkt_done one cycle later.
- Backpressure: pkt_len=2; write 0xA1, 0xA2; tready low 5 cycles → tdata holds 0xA1 with tvalid=1; on release, 2 beats with tlast on 0xA2.
- Full: DEPTH+2 writes with tready=0 → wr_full=1, fifo_count=16, last two words dropped; draining outputs words 0–15 only.
- Starvation and length: pkt_len=4; 2 words written, gap, 2 more; pkt_len changed to 1 during the gap → tvalid drops in the gap, tlast on the 4th word, the next packet is single-beat.
- Reset and zero length: reset after 1 of 3 beats → fifo_count=0, tvalid=0, IDLE; then pkt_len=0 with a write of 0x7 → one beat with tlast=1.

Source files
------------

// File: rtl/axis_burst_tx_pkg.sv
// Shared defaults and packetizer state encoding for axis_burst_tx.
package axis_burst_tx_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 16;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int LEN_WIDTH_DEF  = 12;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with head-of-queue read data and occupancy count.
// Writes while full are dropped even when a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full_o    = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign wr_acc    = wr_en_i & ~full_o;
  assign rd_acc    = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axis_burst_tx.sv
// Buffers words and streams them as AXI-Stream packets of pkt_len beats (0 treated as 1).
// tvalid follows buffer occupancy; tdata is the FIFO head and holds under backpressure.
module axis_burst_tx
  import axis_burst_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                    m01_axis_aclk,
  input  logic                    m01_axis_aresetn,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_full,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  input  logic                    m01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  output logic [ADDR_WIDTH:0]     fifo_count,
  output logic                    pkt_done
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 pkt_done_q, pkt_done_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 hs;
  logic                 last_term;
  logic [LEN_WIDTH-1:0] eff_len;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk_i     (m01_axis_aclk),
    .rst_ni    (m01_axis_aresetn),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (hs),
    .rd_data_o (m01_axis_tdata),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Outputs are gated by reset so they read zero before the first reset edge.
  assign m01_axis_tvalid = m01_axis_aresetn & ~fifo_empty;
  assign wr_full         = m01_axis_aresetn & fifo_full;
  assign m01_axis_tstrb  = {STRB_W{m01_axis_tvalid}};
  assign hs              = m01_axis_tvalid & m01_axis_tready;
  assign eff_len         = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
  assign last_term       = (state_q == ST_IDLE) ? (eff_len == LEN_WIDTH'(1))
                                                : (beat_cnt_q == len_q - LEN_WIDTH'(1));
  assign m01_axis_tlast  = m01_axis_tvalid & last_term;
  assign pkt_done        = pkt_done_q;

  always_ff @(posedge m01_axis_aclk) begin
    if (!m01_axis_aresetn) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    pkt_done_d = hs & last_term;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          len_d = eff_len;
          if (eff_len == LEN_WIDTH'(1)) begin
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = LEN_WIDTH'(1);
            state_d    = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        // An empty buffer simply produces no handshake, so the packet stalls in place.
        if (hs) begin
          beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          if (beat_cnt_q == len_q - LEN_WIDTH'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_burst_tx.sv
// Directed bench for axis_burst_tx: per-cycle vector table plus multi-cycle corner sequences.
module tb_axis_burst_tx;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_full;
  logic [11:0] pkt_len;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tvalid;
  logic        tlast;
  logic [4:0]  fifo_count;
  logic        pkt_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_burst_tx #(
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .ADDR_WIDTH (4),
    .LEN_WIDTH  (12)
  ) dut (
    .m01_axis_aclk    (clk),
    .m01_axis_aresetn (aresetn),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .wr_full          (wr_full),
    .pkt_len          (pkt_len),
    .m01_axis_tready  (tready),
    .m01_axis_tdata   (tdata),
    .m01_axis_tstrb   (tstrb),
    .m01_axis_tvalid  (tvalid),
    .m01_axis_tlast   (tlast),
    .fifo_count       (fifo_count),
    .pkt_done         (pkt_done)
  );

  typedef struct {
    logic        wr;
    logic [31:0] wd;
    logic        rdy;
    logic [11:0] len;
    logic        vld;
    logic [31:0] dat;
    logic        last;
    logic [4:0]  cnt;
    logic        pd;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] wd, input logic rdy, input logic [11:0] len,
                     input logic vld, input logic [31:0] dat, input logic last,
                     input logic [4:0] cnt, input logic pd);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rdy = rdy; v.len = len;
    v.vld = vld; v.dat = dat; v.last = last; v.cnt = cnt; v.pd = pd;
    tbl.push_back(v);
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    wr_en   = 1'b0;
    tready  = 1'b0;
    #1;
    check("rst_tvalid_pre", tvalid, 0);
    check("rst_wrfull_pre", wr_full, 0);
    repeat (2) @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tstrb", tstrb, 0);
    check("rst_wrfull", wr_full, 0);
    check("rst_count", fifo_count, 0);
    check("rst_pkt_done", pkt_done, 0);
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int beats;
    int pd_cnt;

    aresetn = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    tready  = 1'b0;
    pkt_len = 12'd1;

    //   wr  wdata     rdy len    vld dat       last cnt pd
    // Basic 3-beat packet
    add(1, 32'h55, 1, 12'd3, 0, 32'h0,  0, 0, 0);
    add(1, 32'h22, 1, 12'd3, 1, 32'h55, 0, 1, 0);
    add(1, 32'h24, 1, 12'd3, 1, 32'h22, 0, 1, 0);
    add(0, 32'h0,  1, 12'd3, 1, 32'h24, 1, 1, 0);
    add(0, 32'h0,  1, 12'd3, 0, 32'h0,  0, 0, 1);
    add(0, 32'h0,  1, 12'd3, 0, 32'h0,  0, 0, 0);
    // Backpressure, tready low for 5 valid cycles
    add(1, 32'hA1, 0, 12'd2, 0, 32'h0,  0, 0, 0);
    add(1, 32'hA2, 0, 12'd2, 1, 32'hA1, 0, 1, 0);
    add(0, 32'h0,  0, 12'd2, 1, 32'hA1, 0, 2, 0);
    add(0, 32'h0,  0, 12'd2, 1, 32'hA1, 0, 2, 0);
    add(0, 32'h0,  0, 12'd2, 1, 32'hA1, 0, 2, 0);
    add(0, 32'h0,  0, 12'd2, 1, 32'hA1, 0, 2, 0);
    add(0, 32'h0,  1, 12'd2, 1, 32'hA1, 0, 2, 0);
    add(0, 32'h0,  1, 12'd2, 1, 32'hA2, 1, 1, 0);
    add(0, 32'h0,  1, 12'd2, 0, 32'h0,  0, 0, 1);
    add(0, 32'h0,  1, 12'd2, 0, 32'h0,  0, 0, 0);
    // Starvation mid-packet with pkt_len changed to 1 during the gap
    add(1, 32'h31, 1, 12'd4, 0, 32'h0,  0, 0, 0);
    add(1, 32'h32, 1, 12'd4, 1, 32'h31, 0, 1, 0);
    add(0, 32'h0,  1, 12'd1, 1, 32'h32, 0, 1, 0);
    add(0, 32'h0,  1, 12'd1, 0, 32'h0,  0, 0, 0);
    add(1, 32'h33, 1, 12'd1, 0, 32'h0,  0, 0, 0);
    add(1, 32'h34, 1, 12'd1, 1, 32'h33, 0, 1, 0);
    add(0, 32'h0,  1, 12'd1, 1, 32'h34, 1, 1, 0);
    add(1, 32'h35, 1, 12'd1, 0, 32'h0,  0, 0, 1);
    add(0, 32'h0,  1, 12'd1, 1, 32'h35, 1, 1, 0);
    add(0, 32'h0,  1, 12'd1, 0, 32'h0,  0, 0, 1);

    do_reset();

    foreach (tbl[i]) begin
      wr_en   = tbl[i].wr;
      wr_data = tbl[i].wd;
      tready  = tbl[i].rdy;
      pkt_len = tbl[i].len;
      #1;
      check($sformatf("v%0d_tvalid", i), tvalid, tbl[i].vld);
      check($sformatf("v%0d_tlast", i), tlast, tbl[i].last);
      check($sformatf("v%0d_count", i), fifo_count, tbl[i].cnt);
      check($sformatf("v%0d_pkt_done", i), pkt_done, tbl[i].pd);
      check($sformatf("v%0d_tstrb", i), tstrb, tbl[i].vld ? 32'hF : 32'h0);
      if (tbl[i].vld) check($sformatf("v%0d_tdata", i), tdata, tbl[i].dat);
      @(negedge clk);
    end

    // Fill past capacity, then drain with a write attempted while full and popping.
    do_reset();
    pkt_len = 12'd4;
    tready  = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h100 + i;
      @(negedge clk);
    end
    wr_en = 1'b0;
    #1;
    check("full_count", fifo_count, 16);
    check("full_wr_full", wr_full, 1);
    check("full_tvalid", tvalid, 1);

    beats  = 0;
    pd_cnt = 0;
    tready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wr_en   = (c == 0);
      wr_data = 32'hDEAD;
      #1;
      if (c == 1) begin
        check("full_pop_drop_count", fifo_count, 15);
        check("full_pop_drop_wr_full", wr_full, 0);
      end
      if (pkt_done) pd_cnt++;
      if (tvalid) begin
        check($sformatf("drain%0d_tdata", beats), tdata, 32'h100 + beats);
        check($sformatf("drain%0d_tlast", beats), tlast, (beats % 4) == 3);
        beats++;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("drain_beats", beats, 16);
    check("drain_pkt_done_pulses", pd_cnt, 4);
    check("drain_tvalid_end", tvalid, 0);

    // Reset during an open packet, then a zero-length packet.
    pkt_len = 12'd3;
    tready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h41 + i;
      @(negedge clk);
    end
    wr_en  = 1'b0;
    tready = 1'b1;
    #1;
    check("mid_tdata", tdata, 32'h41);
    check("mid_tlast", tlast, 0);
    @(negedge clk);
    tready = 1'b0;
    #1;
    check("mid_count", fifo_count, 2);
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tlast", tlast, 0);
    check("mid_rst_tstrb", tstrb, 0);
    check("mid_rst_wr_full", wr_full, 0);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    check("post_rst_count", fifo_count, 0);
    check("post_rst_tvalid", tvalid, 0);
    check("post_rst_pkt_done", pkt_done, 0);

    pkt_len = 12'd0;
    wr_en   = 1'b1;
    wr_data = 32'h7;
    tready  = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("zero_len_tvalid", tvalid, 1);
    check("zero_len_tdata", tdata, 32'h7);
    check("zero_len_tlast", tlast, 1);
    check("zero_len_count", fifo_count, 1);
    @(negedge clk);
    #1;
    check("zero_len_pkt_done", pkt_done, 1);
    check("zero_len_tvalid_after", tvalid, 0);
    @(negedge clk);
    #1;
    check("zero_len_pkt_done_clear", pkt_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
